ball_sched: RTL
===============

BALL_SCHED -- requirements
Module: ball_sched

Interface
REQ-001 Parameter NUM_BALLS, default 4, number of ball objects sequenced (2..8).
REQ-002 Parameter X_RES, default 640, visible width in pixels.
REQ-003 Parameter Y_RES, default 480, visible height in lines.
REQ-004 clk  input  1  pixel clock, sole clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 i_hcnt  input  11  current horizontal pixel counter.
REQ-007 i_vcnt  input  11  current vertical line counter.
REQ-008 i_width  input  11  ball bounding-box width, common to all balls.
REQ-009 i_height  input  11  ball bounding-box height, common to all balls.
REQ-010 i_enable  input  NUM_BALLS  per-ball enable; disabled balls neither move nor draw.
REQ-011 i_opposite  input  1  one-cycle request to negate all velocities.
REQ-012 o_draw  output  1  pixel at (i_hcnt,i_vcnt) belongs to some enabled ball.
REQ-013 o_ball_id  output  3  index of the winning ball when o_draw=1, else 0.
REQ-014 o_busy  output  1  update sequence in progress.
REQ-015 o_frame_done  output  1  one-cycle pulse when all balls are updated.

Function
REQ-016 Frame start: the cycle where i_hcnt==0 and i_vcnt==0.
REQ-017 FSM states: IDLE, UPDATE, DONE; reset state IDLE.
REQ-018 IDLE->UPDATE on frame start, index reset to 0; o_busy=1 in UPDATE and DONE.
REQ-019 UPDATE: one ball per cycle, index 0..NUM_BALLS-1, then ->DONE; DONE lasts 1 cycle, pulses o_frame_done, then ->IDLE.
REQ-020 A frame start seen outside IDLE is ignored.
REQ-021 State per ball: x, y (11-bit unsigned), dx, dy (11-bit two's complement).
REQ-022 A disabled ball's update cycle is still consumed, but its state is left unchanged.
REQ-023 X step, dx>=0: if x+dx >= X_RES-i_width, set x=X_RES-i_width and dx=-dx; else x=x+dx.
REQ-024 X step, dx<0: if x < |dx|, set x=0 and dx=-dx; else x=x+dx.
REQ-025 Y step: same rules as X, using y, dy, Y_RES and i_height.
REQ-026 Compare sums are computed 12-bit with no wrap-around; if i_width>=X_RES, the bound is 0.
REQ-027 i_opposite while IDLE or DONE is latched as pending.
REQ-028 i_opposite during UPDATE is latched as pending for the next frame and never applied mid-sweep.
REQ-029 Pending opposite: on the next UPDATE, each enabled ball negates dx and dy before the bounce rule; pending clears on entry to DONE.
REQ-030 Draw hit for ball i: enabled, x<=i_hcnt<x+i_width, and y<=i_vcnt<y+i_height.
REQ-031 Arbitration: fixed priority, lowest index wins.
REQ-032 o_draw and o_ball_id are registered, 1-cycle latency from i_hcnt/i_vcnt.
REQ-033 Draw uses current registered positions; an update in flight may tear at most NUM_BALLS+1 pixels at frame origin (accepted).

Reset
REQ-034 On rst, state=IDLE, index=0, pending=0, o_draw=0, o_ball_id=0, o_busy=0, o_frame_done=0.
REQ-035 On rst, ball i gets x=START_X+64*i, y=START_Y+48*i, dx=+1 if i even / -1 if odd, dy=+1.
REQ-036 rst asserted mid-UPDATE aborts the sweep; all balls return to REQ-035 values and no o_frame_done is issued.

Structure
REQ-037 Package ball_pkg holds START_X=0, START_Y=0, the 64/48 spacing constants, the FSM state encoding, and the per-ball state record type.
REQ-038 Sub-module ball_step is combinational: (pos, delta, size, res, flip) -> (next pos, next delta); one instance per axis, shared across balls by index.

Verification
REQ-039 Reset, then one frame start, all enabled -> o_busy high for 5 cycles; o_frame_done on the 5th cycle after the start; ball0=(1,1), ball1 dx=-1 gives x 64->63.
REQ-040 Ball0 x=598, dx=+3, i_width=40 -> x=600, dx=-3; next frame x=597.
REQ-041 Ball1 x=2, dx=-5 -> x=0, dx=+5.
REQ-042 i_opposite pulsed during UPDATE -> current sweep unaffected; next frame all enabled balls' deltas negated, then pending=0.
REQ-043 Balls 0 and 2 overlap at pixel (100,100) -> o_draw=1, o_ball_id=0 one cycle after (100,100) is presented; disable ball0 -> o_ball_id=2.
REQ-044 rst asserted on the 2nd UPDATE cycle -> no o_frame_done; positions equal the REQ-035 values; next frame behaves as the first scenario.

Source files
------------

// File: rtl/ball_pkg.sv
// ball_pkg: shared constants, sequencer state encoding and per-ball state record.
`default_nettype none

package ball_pkg;

    localparam logic [10:0] START_X = 11'd0;
    localparam logic [10:0] START_Y = 11'd0;
    localparam int          SPACE_X = 64;
    localparam int          SPACE_Y = 48;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [10:0] dx;
        logic [10:0] dy;
    } ball_t;

    // Power-on placement: staggered diagonally, odd balls start moving left.
    function automatic ball_t reset_ball(input int i);
        ball_t b;
        b.x  = START_X + 11'(SPACE_X * i);
        b.y  = START_Y + 11'(SPACE_Y * i);
        b.dx = i[0] ? 11'h7FF : 11'd1;
        b.dy = 11'd1;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ball_step.sv
// ball_step: one-axis position update with wall bounce and optional pre-negation.
`default_nettype none

module ball_step (
    input  logic [10:0] pos,
    input  logic [10:0] delta,
    input  logic [10:0] size,
    input  logic [10:0] res,
    input  logic        flip,
    output logic [10:0] next_pos,
    output logic [10:0] next_delta
);

    logic [10:0] d;
    logic [11:0] bound;
    logic [11:0] sum;
    logic [11:0] mag;

    always_comb begin
        d     = flip ? (~delta + 11'd1) : delta;
        // 12-bit arithmetic keeps the compares free of wrap-around.
        bound = (size >= res) ? 12'd0 : ({1'b0, res} - {1'b0, size});
        sum   = {1'b0, pos} + {1'b0, d};
        mag   = 12'd0 - {d[10], d};
        next_pos   = pos;
        next_delta = d;
        if (!d[10]) begin
            if (sum >= bound) begin
                next_pos   = bound[10:0];
                next_delta = ~d + 11'd1;
            end else begin
                next_pos = sum[10:0];
            end
        end else begin
            if ({1'b0, pos} < mag) begin
                next_pos   = 11'd0;
                next_delta = ~d + 11'd1;
            end else begin
                next_pos = pos + d;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ball_sched.sv
// ball_sched: per-frame ball position sequencer with fixed-priority pixel hit arbitration.
`default_nettype none

module ball_sched
    import ball_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int X_RES     = 640,
    parameter int Y_RES     = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10:0]          i_hcnt,
    input  logic [10:0]          i_vcnt,
    input  logic [10:0]          i_width,
    input  logic [10:0]          i_height,
    input  logic [NUM_BALLS-1:0] i_enable,
    input  logic                 i_opposite,
    output logic                 o_draw,
    output logic [2:0]           o_ball_id,
    output logic                 o_busy,
    output logic                 o_frame_done
);

    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BALLS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             pending;
    logic             late;
    ball_t            balls [NUM_BALLS];

    ball_t            cur;
    logic [10:0]      nx, ndx, ny, ndy;
    logic             frame_start;
    logic             hit;
    logic [2:0]       hit_id;

    assign frame_start = (i_hcnt == 11'd0) && (i_vcnt == 11'd0);
    assign cur         = balls[idx];

    ball_step u_step_x (
        .pos        (cur.x),
        .delta      (cur.dx),
        .size       (i_width),
        .res        (11'(X_RES)),
        .flip       (pending),
        .next_pos   (nx),
        .next_delta (ndx)
    );

    ball_step u_step_y (
        .pos        (cur.y),
        .delta      (cur.dy),
        .size       (i_height),
        .res        (11'(Y_RES)),
        .flip       (pending),
        .next_pos   (ny),
        .next_delta (ndy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            pending      <= 1'b0;
            late         <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                balls[i] <= reset_ball(i);
            end
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_opposite) pending <= 1'b1;
                    if (frame_start) begin
                        state  <= ST_UPDATE;
                        idx    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    // Requests arriving mid-sweep are held back for the next frame.
                    if (i_opposite) late <= 1'b1;
                    if (i_enable[idx]) begin
                        balls[idx].x  <= nx;
                        balls[idx].dx <= ndx;
                        balls[idx].y  <= ny;
                        balls[idx].dy <= ndy;
                    end
                    if (idx == LAST_IDX) begin
                        state        <= ST_DONE;
                        o_frame_done <= 1'b1;
                        pending      <= late | i_opposite;
                        late         <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_opposite) pending <= 1'b1;
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Scan from the top index down so the lowest-numbered hit is the last writer.
    always_comb begin
        hit    = 1'b0;
        hit_id = 3'd0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (i_enable[i] &&
                ({1'b0, i_hcnt} >= {1'b0, balls[i].x}) &&
                ({1'b0, i_hcnt} <  ({1'b0, balls[i].x} + {1'b0, i_width})) &&
                ({1'b0, i_vcnt} >= {1'b0, balls[i].y}) &&
                ({1'b0, i_vcnt} <  ({1'b0, balls[i].y} + {1'b0, i_height}))) begin
                hit    = 1'b1;
                hit_id = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_draw    <= 1'b0;
            o_ball_id <= 3'd0;
        end else begin
            o_draw    <= hit;
            o_ball_id <= hit_id;
        end
    end

endmodule

`default_nettype wire
